uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo_if.sv | 36 +++
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Consumer-side read/status bundle of the fabric UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       overrun;
    logic       frame_err;
    logic       fab_int;

    modport slave (
        input  rd_en,
        input  clr_err,
        output rd_data,
        output rd_valid,
        output overrun,
        output frame_err,
        output fab_int
    );

    modport master (
        output rd_en,
        output clr_err,
        input  rd_data,
        input  rd_valid,
        input  overrun,
        input  frame_err,
        input  fab_int
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver with centre sampling feeding a show-ahead FIFO
//            and a level interrupt while data is pending.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         rxd,
    uart_rx_fifo_if.slave     bus
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detect (idle level is high)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rxs;
    logic r_rxs_d;
    logic w_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    assign w_fall = r_rxs_d & ~r_rxs;

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_frame_err;
    logic              w_bit_end;
    logic              w_push;

    assign w_bit_end = (r_cnt == c_BIT_LAST);
    // A good stop bit commits the byte in the same cycle it is sampled.
    assign w_push    = (r_state == S_STOP) && w_bit_end && r_rxs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Held-low line: stay here so only one frame error is reported.
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO with extra-MSB pointers
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            r_overrun;
    logic            r_fab_int;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = bus.rd_en & ~w_empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
            r_fab_int <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end
            r_fab_int <= ~w_empty;
        end
    end

    assign bus.rd_data   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign bus.rd_valid  = ~w_empty;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
    assign bus.fab_int   = r_fab_int;

endmodule
`default_nettype wire
